// File: rtl/osf_window3x3.sv
// 3x3 sliding-window generator for the order-statistics filter.
// Two line buffers hold the previous two rows; a 3x3 register array assembles each window.
module osf_window3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    din_valid,
  input  logic                    din_sof,
  output logic [9*DATA_WIDTH-1:0] win,
  output logic                    win_valid,
  output logic                    win_last
);

  localparam int AW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [AW-1:0] COL_LAST = AW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [AW-1:0] col_reg, col_next, pos_col;
  logic [RW-1:0] row_reg, row_next, pos_row;
  logic          col_wrap, row_wrap, emit, emit_last;

  logic [DATA_WIDTH-1:0] lb0_mem [0:IMG_WIDTH-1];
  logic [DATA_WIDTH-1:0] lb1_mem [0:IMG_WIDTH-1];
  logic [DATA_WIDTH-1:0] lb0_rd, lb1_rd;

  // sr_reg[row][col]: row 0 is the oldest line, col 0 the oldest pixel
  logic [DATA_WIDTH-1:0] sr_reg  [0:2][0:2];
  logic [DATA_WIDTH-1:0] sr_next [0:2][0:2];

  logic [9*DATA_WIDTH-1:0] win_reg, win_next;
  logic                    win_valid_reg, win_last_reg;

  // A start-of-frame pixel is position (0,0) no matter where the counters are.
  always_comb begin
    pos_col  = din_sof ? '0 : col_reg;
    pos_row  = din_sof ? '0 : row_reg;
    col_wrap = (pos_col == COL_LAST);
    row_wrap = (pos_row == ROW_LAST);
    col_next = col_wrap ? '0 : pos_col + 1'b1;
    if (col_wrap) begin
      row_next = row_wrap ? '0 : pos_row + 1'b1;
    end else begin
      row_next = pos_row;
    end
    emit      = din_valid && (pos_row >= RW'(2)) && (pos_col >= AW'(2));
    emit_last = emit && row_wrap && col_wrap;
  end

  assign lb0_rd = lb0_mem[pos_col];
  assign lb1_rd = lb1_mem[pos_col];

  // Read-before-write: lb1 receives the value lb0 held before this write.
  always_ff @(posedge clk) begin
    if (din_valid && !rst) begin
      lb0_mem[pos_col] <= din;
      lb1_mem[pos_col] <= lb0_rd;
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      sr_next[r][0] = sr_reg[r][1];
      sr_next[r][1] = sr_reg[r][2];
    end
    sr_next[0][2] = lb1_rd;
    sr_next[1][2] = lb0_rd;
    sr_next[2][2] = din;
  end

  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_pack
      assign win_next[gi*DATA_WIDTH +: DATA_WIDTH] = sr_next[gi/3][gi%3];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg       <= '0;
      row_reg       <= '0;
      win_reg       <= '0;
      win_valid_reg <= 1'b0;
      win_last_reg  <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          sr_reg[r][c] <= '0;
        end
      end
    end else begin
      win_valid_reg <= emit;
      win_last_reg  <= emit_last;
      if (din_valid) begin
        col_reg <= col_next;
        row_reg <= row_next;
        sr_reg  <= sr_next;
      end
      if (emit) begin
        win_reg <= win_next;
      end
    end
  end

  assign win       = win_reg;
  assign win_valid = win_valid_reg;
  assign win_last  = win_last_reg;

endmodule
